fifo_capture: RTL and testbench
===============================

FIFO_CAPTURE -- requirements
Module: fifo_capture

Interface
REQ-001 The module SHALL have parameter DW, default 8, sample data width in bits.
REQ-002 The module SHALL have parameter AW, default 10, address width; DEPTH = 2^AW entries.
REQ-003 The module SHALL have parameter PRE_DEPTH, default 16, pre-trigger sample count, legal range 1..DEPTH-1.
REQ-004 The module SHALL use one clock and a synchronous, active-high reset.
REQ-005 The module SHALL have these ports (name, direction, width, meaning):
- clk_in  in  1  sole clock; all logic on its rising edge
- rst  in  1  synchronous active-high reset
- arm  in  1  start or restart a capture
- trig  in  1  trigger qualifier
- wr_valid  in  1  data_in is a valid sample this cycle
- data_in  in  DW  sample data
- rd_req  in  1  read request, READ state only
- q  out  DW  registered read data
- q_valid  out  1  q updated this cycle
- counter  out  AW+1  entries held, 0..DEPTH
- full  out  1  counter == DEPTH
- empty  out  1  counter == 0
- state  out  2  IDLE=0, PRE=1, POST=2, READ=3
- done  out  1  capture complete, data readable

Function
REQ-006 Storage SHALL be a DEPTH x DW memory with AW-bit wr_ptr and rd_ptr that wrap from DEPTH-1 to 0.
REQ-007 full and empty SHALL be combinational decodes of counter.
REQ-008 In IDLE, wr_valid and rd_req SHALL be ignored; arm=1 SHALL clear wr_ptr, rd_ptr, counter and done, and enter PRE on the next cycle.
REQ-009 In PRE, wr_valid=1 SHALL write data_in at wr_ptr and increment wr_ptr.
REQ-010 In PRE, while counter < PRE_DEPTH, each write SHALL increment counter.
REQ-011 In PRE, once counter >= PRE_DEPTH, each write SHALL also advance rd_ptr so the oldest sample is dropped and counter stays unchanged (rolling window).
REQ-012 In PRE, trig=1 with counter >= PRE_DEPTH SHALL enter POST on the next cycle.
REQ-013 A sample written in the trigger cycle SHALL be retained.
REQ-014 trig in PRE with counter < PRE_DEPTH SHALL be ignored.
REQ-015 In POST, each wr_valid write SHALL increment counter; trig SHALL be ignored.
REQ-016 The POST write that makes counter == DEPTH SHALL enter READ and set done=1 on the next cycle; no write SHALL occur while full.
REQ-017 In READ, wr_valid SHALL be ignored.
REQ-018 In READ, rd_req=1 with empty=0 SHALL load mem[rd_ptr] into q, increment rd_ptr, decrement counter, and assert q_valid, all on the next edge (latency 1).
REQ-019 In READ, rd_req with empty=1 SHALL be ignored and q SHALL hold its value.
REQ-020 q_valid SHALL be a single-cycle pulse per accepted read.
REQ-021 After draining, the block SHALL remain in READ with done=1, empty=1 until arm.
REQ-022 arm=1 in PRE, POST or READ SHALL restart exactly as in REQ-008; arm SHALL take precedence over trig, wr_valid and rd_req in the same cycle.
REQ-023 Read-out order SHALL be oldest first: the PRE_DEPTH pre-trigger samples (including the trigger-cycle sample), then post-trigger samples.
REQ-024 counter arithmetic SHALL use AW+1 bits and SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-025 rst=1 at a clock edge SHALL force state=IDLE, wr_ptr=rd_ptr=0, counter=0, q=0, q_valid=0, done=0, regardless of state or other inputs.
REQ-026 Memory contents SHALL NOT require reset.
REQ-027 Reset asserted mid-capture or mid-readout SHALL abort the operation with no further writes or reads.

Verification
REQ-028 Reset, then arm; stream 0,1,2,... with wr_valid=1 → counter saturates at 16; rd_ptr tracks wr_ptr-16.
REQ-029 DW=8, AW=4, PRE_DEPTH=4: stream 0..9, trig with sample 9, continue streaming → done after counter=16; reads return 6,7,8,9,10..21, each with q_valid one cycle after rd_req.
REQ-030 trig asserted at counter=2 (PRE_DEPTH=4) → stays PRE; a later trig at counter=4 → enters POST.
REQ-031 Drain to empty, then rd_req held high for 3 cycles → q unchanged, q_valid=0, counter=0.
REQ-032 arm together with trig and wr_valid during PRE → next state PRE, counter=0, no write.
REQ-033 rst pulsed during POST with wr_valid=1 → next cycle state=IDLE, counter=0, done=0.

Source files
------------

// File: rtl/fifo_capture.sv
// Pre/post-trigger capture buffer: keeps a rolling window of PRE_DEPTH samples
// before a qualified trigger, fills the rest of the memory, then drains oldest-first.
module fifo_capture #(
    parameter int DW        = 8,
    parameter int AW        = 10,
    parameter int PRE_DEPTH = 16
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          arm,
    input  logic          trig,
    input  logic          wr_valid,
    input  logic [DW-1:0] data_in,
    input  logic          rd_req,
    output logic [DW-1:0] q,
    output logic          q_valid,
    output logic [AW:0]   counter,
    output logic          full,
    output logic          empty,
    output logic [1:0]    state,
    output logic          done
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRE_C   = (AW+1)'(PRE_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        READ = 2'd3
    } state_t;

    state_t        st;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pre_full;
    logic          wr_en;
    logic          rd_en;

    assign state    = st;
    assign full     = (counter == DEPTH_C);
    assign empty    = (counter == '0);
    assign pre_full = (counter >= PRE_C);

    // arm wins over every other input, so it gates both memory ports.
    assign wr_en = !arm && wr_valid && ((st == PRE) || (st == POST && !full));
    assign rd_en = !arm && rd_req && (st == READ) && !empty;

    always_ff @(posedge clk_in) begin
        if (wr_en && !rst)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            st      <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            counter <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            if (arm) begin
                st      <= PRE;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                counter <= '0;
                done    <= 1'b0;
            end else begin
                case (st)
                    IDLE: ;
                    PRE: begin
                        // Once the window is full, each write drops the oldest sample.
                        if (wr_en) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (pre_full)
                                rd_ptr <= rd_ptr + 1'b1;
                            else
                                counter <= counter + 1'b1;
                        end
                        if (trig && pre_full)
                            st <= POST;
                    end
                    POST: begin
                        if (wr_en) begin
                            wr_ptr  <= wr_ptr + 1'b1;
                            counter <= counter + 1'b1;
                            if (counter == DEPTH_C - 1'b1) begin
                                st   <= READ;
                                done <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (rd_en) begin
                            q       <= mem[rd_ptr];
                            rd_ptr  <= rd_ptr + 1'b1;
                            counter <= counter - 1'b1;
                            q_valid <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_capture.sv
// Directed bench for fifo_capture with DW=8, AW=4, PRE_DEPTH=4.
module tb_fifo_capture;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PD = 4;

    logic          clk_in = 1'b0;
    logic          rst, arm, trig, wr_valid, rd_req;
    logic [DW-1:0] data_in;
    logic [DW-1:0] q;
    logic          q_valid, full, empty, done;
    logic [AW:0]   counter;
    logic [1:0]    state;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_capture #(.DW(DW), .AW(AW), .PRE_DEPTH(PD)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .arm     (arm),
        .trig    (trig),
        .wr_valid(wr_valid),
        .data_in (data_in),
        .rd_req  (rd_req),
        .q       (q),
        .q_valid (q_valid),
        .counter (counter),
        .full    (full),
        .empty   (empty),
        .state   (state),
        .done    (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int d, input logic t);
        wr_valid = 1'b1;
        data_in  = DW'(d);
        trig     = t;
        tick();
        wr_valid = 1'b0;
        trig     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; data_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_counter", counter, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_qvalid", q_valid, 0);

        // IDLE ignores writes
        wr(5, 1'b1);
        chk("idle_state", state, 0);
        chk("idle_counter", counter, 0);

        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_state", state, 1);
        chk("arm_counter", counter, 0);

        wr(0, 1'b0);
        wr(1, 1'b0);
        chk("pre_cnt2", counter, 2);
        wr(2, 1'b1);                        // trig below PRE_DEPTH is ignored
        chk("early_trig_state", state, 1);
        chk("early_trig_cnt", counter, 3);
        wr(3, 1'b0);
        chk("pre_cnt4", counter, 4);
        for (int i = 4; i <= 8; i++) begin
            wr(i, 1'b0);
            chk("pre_saturate", counter, 4);
        end
        wr(9, 1'b1);
        chk("trig_state", state, 2);
        chk("trig_cnt", counter, 4);

        tick();                             // idle cycle in POST
        chk("post_gap_cnt", counter, 4);
        for (int i = 10; i <= 20; i++) wr(i, 1'b1);
        chk("post_state", state, 2);
        chk("post_cnt15", counter, 15);
        chk("post_done0", done, 0);
        wr(21, 1'b0);
        chk("read_state", state, 3);
        chk("read_cnt", counter, 16);
        chk("read_full", full, 1);
        chk("read_done", done, 1);

        wr(99, 1'b0);                       // writes ignored in READ
        chk("read_wr_ignored", counter, 16);

        rd_req = 1'b1; tick(); rd_req = 1'b0;
        chk("rd0_qvalid", q_valid, 1);
        chk("rd0_q", q, 6);
        chk("rd0_cnt", counter, 15);
        tick();
        chk("rd0_pulse", q_valid, 0);
        chk("rd0_hold", q, 6);

        rd_req = 1'b1;
        for (int i = 7; i <= 21; i++) begin
            tick();
            chk("rd_q", q, i);
            chk("rd_qvalid", q_valid, 1);
        end
        rd_req = 1'b1;
        chk("drain_cnt", counter, 0);
        chk("drain_empty", empty, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_rd_q", q, 21);
            chk("empty_rd_qvalid", q_valid, 0);
            chk("empty_rd_cnt", counter, 0);
        end
        rd_req = 1'b0;
        chk("drained_state", state, 3);
        chk("drained_done", done, 1);

        arm = 1'b1; tick(); arm = 1'b0;
        chk("rearm_state", state, 1);
        chk("rearm_done", done, 0);
        chk("rearm_cnt", counter, 0);
        for (int i = 30; i <= 33; i++) wr(i, 1'b0);
        chk("rearm_fill", counter, 4);

        // arm beats trig and wr_valid
        arm = 1'b1; trig = 1'b1; wr_valid = 1'b1; data_in = 8'd77;
        tick();
        arm = 1'b0; trig = 1'b0; wr_valid = 1'b0;
        chk("arm_prec_state", state, 1);
        chk("arm_prec_cnt", counter, 0);

        for (int i = 40; i <= 43; i++) wr(i, 1'b0);
        wr(44, 1'b1);
        chk("cap2_post", state, 2);
        for (int i = 45; i <= 56; i++) wr(i, 1'b0);
        chk("cap2_read", state, 3);
        rd_req = 1'b1; tick();
        chk("cap2_q0", q, 41);
        tick(); rd_req = 1'b0;
        chk("cap2_q1", q, 42);
        chk("cap2_cnt", counter, 14);

        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i <= 3; i++) wr(i, 1'b0);
        wr(4, 1'b1);
        wr(5, 1'b0);
        chk("cap3_post", state, 2);
        chk("cap3_cnt", counter, 5);
        rst = 1'b1; wr_valid = 1'b1; data_in = 8'd88;
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        chk("midrst_state", state, 0);
        chk("midrst_cnt", counter, 0);
        chk("midrst_done", done, 0);
        chk("midrst_q", q, 0);
        chk("midrst_qvalid", q_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
